// File: rtl/aap_pkg.sv
// aap_pkg: AAP halfword field positions and instruction class encodings
package aap_pkg;
  localparam int HW_W = 16;
  localparam int LONG_BIT = 15;
  localparam int CLASS_HI = 14;
  localparam int CLASS_LO = 13;
  localparam int OPC_HI = 12;
  localparam int OPC_LO = 9;
  localparam int RD_HI = 8;
  localparam int RD_LO = 6;
  localparam int RA_HI = 5;
  localparam int RA_LO = 3;
  localparam int RB_HI = 2;
  localparam int RB_LO = 0;
  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_MEM  = 2'd1,
    CLS_FLOW = 2'd2,
    CLS_MISC = 2'd3
  } cls_e;
endpackage

// File: rtl/aap_fetch_decode_if.sv
// aap_fetch_decode_if: divider control, instruction memory port, redirect and decode handshake
interface aap_fetch_decode_if #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 10
);
  logic [DIV_W-1:0]        div_limit;
  logic                    tick;
  logic                    imem_req;
  logic [ADDR_W-1:0]       imem_addr;
  logic [15:0]             imem_rdata;
  logic                    redirect;
  logic [ADDR_W-1:0]       redirect_pc;
  logic                    dec_valid;
  logic                    dec_ready;
  logic [ADDR_W-1:0]       dec_pc;
  logic                    dec_long;
  logic [1:0]              dec_class;
  logic [3:0]              dec_opcode;
  logic [2:0]              dec_rd;
  logic [2:0]              dec_ra;
  logic [2:0]              dec_rb;
  logic [15:0]             dec_ext;
  logic [$clog2(DEPTH):0]  fifo_level;
  modport master (
    input  div_limit, imem_rdata, redirect, redirect_pc, dec_ready,
    output tick, imem_req, imem_addr, dec_valid, dec_pc, dec_long, dec_class,
           dec_opcode, dec_rd, dec_ra, dec_rb, dec_ext, fifo_level
  );
  modport slave (
    output div_limit, imem_rdata, redirect, redirect_pc, dec_ready,
    input  tick, imem_req, imem_addr, dec_valid, dec_pc, dec_long, dec_class,
           dec_opcode, dec_rd, dec_ra, dec_rb, dec_ext, fifo_level
  );
endinterface

// File: rtl/aap_prefetch_fifo.sv
// aap_prefetch_fifo: circular halfword buffer with push-1, pop-1-or-2, flush and head/head+1 peek
module aap_prefetch_fifo
  import aap_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [HW_W-1:0]        push_data_i,
  input  logic [ADDR_W-1:0]      push_pc_i,
  input  logic [1:0]             pop_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [HW_W-1:0]        head_data_o,
  output logic [HW_W-1:0]        next_data_o,
  output logic [ADDR_W-1:0]      head_pc_o
);
  localparam int PW = $clog2(DEPTH);
  logic [HW_W-1:0]   data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       level_q;
  // storage needs no reset: the level decides what is visible
  always_ff @(posedge clock)
    if (push_i) begin
      data_q[wr_q] <= push_data_i;
      pc_q[wr_q]   <= push_pc_i;
    end
  // pointers and occupancy; flush discards everything including a same-cycle push
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_q + PW'(push_i);
      rd_q    <= rd_q + PW'(pop_i);
      level_q <= level_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  assign level_o     = level_q;
  assign head_data_o = data_q[rd_q];
  assign next_data_o = data_q[rd_q + PW'(1)];
  assign head_pc_o   = pc_q[rd_q];
endmodule

// File: rtl/aap_fetch_decode.sv
// aap_fetch_decode: clock-enable divider, halfword fetch, prefetch buffer and AAP field decode
module aap_fetch_decode
  import aap_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 10
) (
  input logic                clock,
  input logic                reset,
  aap_fetch_decode_if.master bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d, head_pc;
  logic              inflight_q, req, long_w, valid;
  logic [LW-1:0]     level;
  logic [HW_W-1:0]   head, nxt;
  logic [1:0]        pop;
  cls_e              cls;
  // tick is held low while reset is asserted so every output reads 0
  assign bus.tick = reset && (cnt_q == bus.div_limit);
  assign req = bus.tick && !bus.redirect &&
               ((LW+1)'(level) + (LW+1)'(inflight_q) < (LW+1)'(DEPTH));
  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  // next divider count and fetch PC; a redirect overrides any advance
  always_comb begin
    cnt_d = bus.tick ? '0 : cnt_q + 1'b1;
    pc_d  = bus.redirect ? bus.redirect_pc : req ? pc_q + 1'b1 : pc_q;
  end
  // divider, fetch PC and the one-cycle in-flight marker
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt_q      <= '0;
      pc_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      inflight_q <= req;
    end
  // pc_q has already advanced past the in-flight address, so it is pc_q - 1
  aap_prefetch_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (bus.redirect),
    .push_i      (inflight_q && !bus.redirect),
    .push_data_i (bus.imem_rdata),
    .push_pc_i   (pc_q - 1'b1),
    .pop_i       (pop),
    .level_o     (level),
    .head_data_o (head),
    .next_data_o (nxt),
    .head_pc_o   (head_pc)
  );
  assign long_w = head[LONG_BIT];
  assign valid  = (level != '0) && (!long_w || level > LW'(1));
  assign pop    = (valid && bus.dec_ready) ? (long_w ? 2'd2 : 2'd1) : 2'd0;
  assign cls    = cls_e'(valid ? head[CLASS_HI:CLASS_LO] : 2'd0);
  assign bus.dec_valid  = valid;
  assign bus.dec_pc     = valid ? head_pc : '0;
  assign bus.dec_long   = valid && long_w;
  assign bus.dec_class  = cls;
  assign bus.dec_opcode = valid ? head[OPC_HI:OPC_LO] : 4'd0;
  assign bus.dec_rd     = valid ? head[RD_HI:RD_LO] : 3'd0;
  assign bus.dec_ra     = valid ? head[RA_HI:RA_LO] : 3'd0;
  assign bus.dec_rb     = valid ? head[RB_HI:RB_LO] : 3'd0;
  assign bus.dec_ext    = (valid && long_w) ? nxt : 16'd0;
  assign bus.fifo_level = level;
endmodule
